// File: rtl/dbus_responder_pkg.sv
// -----------------------------------------------------------------------------
// dbus_responder_pkg
//   Shared types for the data-bus responder slice: access-size encoding,
//   latched request record, response record and the responder FSM states.
//   Imported by dbus_responder and dbus_resp_ram.
//
//   Optional feature macro used by the importing RTL:
//     DBUS_RESPONDER_ALIGN_CHECK_EN  - flag and suppress misaligned accesses.
// -----------------------------------------------------------------------------
package dbus_responder_pkg;

    // Access size as log2(bytes); same encoding as the common msize_t.
    typedef enum logic [2:0] {
        MSIZE_1B = 3'd0,
        MSIZE_2B = 3'd1,
        MSIZE_4B = 3'd2,
        MSIZE_8B = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dbus_state_t;

    // Request fields captured at acceptance and held for the transaction.
    typedef struct packed {
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
        logic        err;
    } dbus_resp_t;

    localparam int CNT_W = 4;

    // True when addr is not a multiple of the access size. Undefined size
    // codes are treated as 8-byte accesses.
    function automatic logic is_misaligned(input logic [63:0] addr, input msize_t size);
        case (size)
            MSIZE_1B: return 1'b0;
            MSIZE_2B: return addr[0];
            MSIZE_4B: return |addr[1:0];
            default:  return |addr[2:0];
        endcase
    endfunction

endpackage

// File: rtl/dbus_resp_ram.sv
// -----------------------------------------------------------------------------
// dbus_resp_ram
//   Word-organised storage for dbus_responder: MEM_WORDS x 64-bit words,
//   one asynchronous read port and one byte-strobed synchronous write port.
//   A read and a write to the same word in the same cycle returns the old
//   word (the write lands at the clock edge).
//
//   Ports:
//     clk          - write clock
//     i_rd_idx     - read word index
//     o_rd_data    - read word
//     i_we         - write enable
//     i_wr_idx     - write word index
//     i_wr_strobe  - per-byte write enables
//     i_wr_data    - write word (lane-aligned)
// -----------------------------------------------------------------------------
module dbus_resp_ram
    import dbus_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_WORDS)-1:0] i_rd_idx,
    output logic [63:0]                  o_rd_data,
    input  logic                         i_we,
    input  logic [$clog2(MEM_WORDS)-1:0] i_wr_idx,
    input  logic [7:0]                   i_wr_strobe,
    input  logic [63:0]                  i_wr_data
);

    logic [63:0] r_mem [MEM_WORDS];

    // NOTE: storage has no reset; clearing a RAM array is not implementable
    // in block memory and its contents must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_wr_strobe[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/dbus_responder.sv
// -----------------------------------------------------------------------------
// dbus_responder
//   Fixed-latency data-bus slave. A request seen in IDLE is accepted in the
//   same cycle (resp_addr_ok), latched, and completed LATENCY cycles later
//   with a one-cycle resp_data_ok. Reads and writes both return the stored
//   word as it was before the transaction; writes update the strobed lanes
//   at the completion edge.
//
//   Parameters:
//     MEM_WORDS  - number of 64-bit storage words (power of two, >= 2)
//     LATENCY    - cycles from acceptance to resp_data_ok (1..15)
//
//   Ports:
//     clk, resetn              - clock, asynchronous active-low reset
//     req_valid                - request valid, held until resp_data_ok
//     req_addr / req_size      - byte address, access size (msize_t code)
//     req_strobe / req_data    - byte write enables (0 = read), store data
//     resp_addr_ok             - request accepted this cycle
//     resp_data_ok             - transaction completes this cycle
//     resp_data / resp_err     - aligned word / misalignment flag
//
//   Build option:
//     DBUS_RESPONDER_ALIGN_CHECK_EN - misaligned accesses complete with
//       resp_err=1, zero data and no storage write. Undefined: resp_err=0
//       and misaligned accesses proceed by strobe and word index.
// -----------------------------------------------------------------------------
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    localparam int             IDX_W  = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    dbus_state_t      r_state;
    dbus_state_t      w_next_state;
    logic [CNT_W-1:0] r_count;
    dbus_req_t        r_req;

    logic             w_accept;
    logic             w_misaligned;
    logic             w_we;
    logic [IDX_W-1:0] w_idx;
    logic [63:0]      w_rd_data;
    dbus_resp_t       w_resp;
    logic             w_unused_addr_bits;

    // Acceptance is gated by resetn so addr_ok stays low throughout reset
    // even while the initiator holds req_valid.
    assign w_accept = (r_state == IDLE) && req_valid && resetn;

    // Upper address bits wrap onto the storage.
    assign w_idx = r_req.addr[3 +: IDX_W];

`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(r_req.addr, r_req.size);
`else
    assign w_misaligned = 1'b0;
`endif

    // Bits deliberately ignored (upper address, and size/offset when the
    // alignment check is built out).
    assign w_unused_addr_bits = ^{r_req.addr, r_req.size};

    assign w_we = (r_state == RESP) && (|r_req.strobe) && !w_misaligned;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: default assignment first so no path through the case leaves
    // w_next_state unassigned (which would infer a latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = (LATENCY == 1) ? RESP : WAIT;
            // The counter holds the remaining wait cycles; RESP follows the
            // cycle in which it steps down to zero.
            WAIT: if (r_count <= CNT_W'(1)) w_next_state = RESP;
            RESP: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- counter and request latch ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
            r_req   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count <= LAT_M1;
                        r_req   <= '{addr:   req_addr,
                                     size:   msize_t'(req_size),
                                     strobe: req_strobe,
                                     data:   req_data};
                    end
                end
                WAIT: r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        w_resp         = '0;
        w_resp.addr_ok = w_accept;
        if (r_state == RESP) begin
            w_resp.data_ok = 1'b1;
            w_resp.data    = w_misaligned ? 64'd0 : w_rd_data;
            w_resp.err     = w_misaligned;
        end
    end

    assign resp_addr_ok = w_resp.addr_ok;
    assign resp_data_ok = w_resp.data_ok;
    assign resp_data    = w_resp.data;
    assign resp_err     = w_resp.err;

    // ---------------- storage ----------------
    dbus_resp_ram #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk         (clk),
        .i_rd_idx    (w_idx),
        .o_rd_data   (w_rd_data),
        .i_we        (w_we),
        .i_wr_idx    (w_idx),
        .i_wr_strobe (r_req.strobe),
        .i_wr_data   (r_req.data)
    );

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 64-bit storage words (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to data_ok (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  data-bus request valid; initiator holds it until data_ok.
REQ-006 SHALL have port req_addr  input  64  byte address.
REQ-007 SHALL have port req_size  input  3  access size, msize_t (1/2/4/8 bytes).
REQ-008 SHALL have port req_strobe  input  8  byte-write enables; all-zero means read.
REQ-009 SHALL have port req_data  input  64  store data, lane-aligned to req_addr[2:0].
REQ-010 SHALL have port resp_addr_ok  output  1  request accepted this cycle.
REQ-011 SHALL have port resp_data_ok  output  1  transaction complete this cycle.
REQ-012 SHALL have port resp_data  output  64  full aligned 64-bit word; valid only with data_ok.
REQ-013 SHALL have port resp_err  output  1  misalignment flag (see Configuration); valid only with data_ok.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 In IDLE with req_valid=1, SHALL assert resp_addr_ok combinationally, latch addr/size/strobe/data, load the counter with LATENCY-1, and go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to RESP when it reaches 0.
REQ-017 In RESP, SHALL assert resp_data_ok for exactly one cycle and return to IDLE.
REQ-018 SHALL never accept a new request outside IDLE; resp_addr_ok=0 in WAIT and RESP.
REQ-019 Back-to-back: a request held high after data_ok SHALL be accepted in the following IDLE cycle; throughput is one transaction per LATENCY+1 cycles.
REQ-020 Word index SHALL be latched_addr[3 +: log2(MEM_WORDS)]; upper address bits ignored (wrap-around).
REQ-021 Reads (strobe=0) SHALL return the stored word on resp_data during RESP.
REQ-022 Writes SHALL update only the byte lanes set in latched strobe, at the RESP clock edge; resp_data in a write's RESP cycle SHALL be the pre-write word.
REQ-023 Deassertion of req_valid after acceptance is a protocol violation; the latched transaction SHALL still complete normally.
REQ-024 Outputs outside RESP: resp_data_ok=0, resp_data=0, resp_err=0.

Reset
REQ-025 resetn=0 SHALL immediately force state IDLE, counter 0, all latched request fields 0, and all outputs 0 except resp_addr_ok, which SHALL be 0 while resetn=0.
REQ-026 Reset mid-transaction SHALL abort it with no data_ok and no storage write.
REQ-027 Storage contents SHALL NOT be reset.

Configuration
REQ-028 Macro DBUS_RESPONDER_ALIGN_CHECK_EN defined: a transaction whose addr is not a multiple of its size SHALL complete with resp_err=1, read data 0, and no storage write.
REQ-029 Macro undefined: resp_err SHALL be tied 0 and misaligned accesses SHALL proceed by strobe/word index unmodified.

Structure
REQ-030 dbus_req_t, dbus_resp_t and the FSM state enum SHALL live in the shared package; msize_t reused from common.
REQ-031 Storage SHALL be a sub-module dbus_resp_ram (one read port, one byte-strobed write port); FSM and counter remain in dbus_responder.

Verification
REQ-032 Reset, then write addr 0x10, strobe 0xFF, data 0x1122334455667788 -> addr_ok cycle 0, data_ok cycle 2 (LATENCY=2); read 0x10 -> resp_data 0x1122334455667788.
REQ-033 Byte write addr 0x13, strobe 0x08, data 0x00000000AA000000 over the prior word -> later read returns 0x11223344AA667788.
REQ-034 req_valid held for 3 reads -> addr_ok at cycles 0,3,6; data_ok at cycles 2,5,8; never two addr_ok without an intervening data_ok.
REQ-035 resetn pulsed low one cycle after accepting a write to 0x20 -> no data_ok; read 0x20 returns the pre-reset contents.
REQ-036 MEM_WORDS=1024: write at 0x2008 then read 0x0008 -> same word returned (wrap-around).
REQ-037 With DBUS_RESPONDER_ALIGN_CHECK_EN: 4-byte write at 0x22 -> resp_err=1, storage unchanged; without macro -> resp_err=0, write applied.
